det_stream_ctrl: RTL and testbench

DET_STREAM_CTRL -- requirements
Module: det_stream_ctrl

---
 rtl/det_stream_pkg.sv | 19 +
 rtl/det_stream_match.sv | 54 +++++
 rtl/det_stream_ctrl.sv | 124 ++++++++++++
 tb/tb_det_stream_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/det_stream_pkg.sv
// det_stream_pkg: shared types and constants for the det_stream_ctrl pattern scanner.
// Holds the FSM state encoding, the default pattern and the result counter width helper.
package det_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  localparam int                   DEF_PAT_W   = 6;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 6'b110011;

  // Bits needed to hold a match count of 0..word_w inclusive.
  function automatic int cnt_width(input int word_w);
    return $clog2(word_w + 1);
  endfunction

endpackage

// File: rtl/det_stream_match.sv
// det_stream_match: bit history, fill counter and pattern compare.
// Only the newest PAT_W-1 history bits are stored; together with the incoming bit
// they form the PAT_W-bit window, and the oldest bit would never be compared again.
module det_stream_match
  import det_stream_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_bit_valid,
  input  logic i_bit,
  output logic o_hit
);

  localparam int               FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_THR = FILL_W'(PAT_W - 1);

  logic [PAT_W-2:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic [PAT_W-1:0]  w_window;

  assign w_window = {r_hist, i_bit};

  // History shifts in each processed bit; fill counts valid bits up to PAT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_bit_valid) begin
      r_hist <= w_window[PAT_W-2:0];
      if (r_fill != FILL_MAX) begin
        r_fill <= r_fill + FILL_W'(1);
      end
    end
  end

  // A hit needs a full window (this bit included) equal to the pattern.
  always_comb begin
    o_hit = 1'b0;
    if (i_bit_valid && (r_fill >= FILL_THR) && (w_window == PATTERN)) begin
      o_hit = 1'b1;
    end else begin
      o_hit = 1'b0;
    end
  end

endmodule

// File: rtl/det_stream_ctrl.sv
// det_stream_ctrl: accepts words, scans them MSB first for PATTERN one bit per cycle,
// and reports the number of matches ending inside each word.
// Optional feature macro: DET_STREAM_STATS_EN adds a saturating 16-bit total_count of all hits.
module det_stream_ctrl
  import det_stream_pkg::*;
#(
  parameter int               WORD_W  = 8,
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WORD_W-1:0]            in_data,
  output logic                         hit,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [cnt_width(WORD_W)-1:0] out_count
`ifdef DET_STREAM_STATS_EN
  ,
  output logic [15:0]                  total_count
`endif
);

  localparam int               CNT_W    = cnt_width(WORD_W);
  localparam int               IDX_W    = $clog2(WORD_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  state_e             r_state;
  state_e             w_next_state;
  logic [WORD_W-1:0]  r_word;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_accept;
  logic               w_clear;
  logic               w_shift;
  logic               w_hit;

  assign w_accept = (r_state == ST_IDLE) && in_valid;
  assign w_clear  = (r_state == ST_IDLE) && flush;
  assign w_shift  = (r_state == ST_SHIFT);

  det_stream_match #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_match (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_clear),
    .i_bit_valid (w_shift),
    .i_bit       (r_word[WORD_W-1]),
    .o_hit       (w_hit)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state: accept, shift WORD_W bits, then hold the result until consumed.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   w_next_state = w_accept ? ST_SHIFT : ST_IDLE;
      ST_SHIFT:  w_next_state = (r_idx == LAST_IDX) ? ST_REPORT : ST_SHIFT;
      ST_REPORT: w_next_state = out_ready ? ST_IDLE : ST_REPORT;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: ready only while idle, result valid only while reporting.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE:   in_ready  = 1'b1;
      ST_SHIFT:  in_ready  = 1'b0;
      ST_REPORT: out_valid = 1'b1;
      default:   in_ready  = 1'b1;
    endcase
  end

  // Word shifter, bit index and per-word match counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word <= '0;
      r_idx  <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_word <= in_data;
      r_idx  <= '0;
      r_cnt  <= '0;
    end else if (w_shift) begin
      r_word <= {r_word[WORD_W-2:0], 1'b0};
      r_idx  <= r_idx + IDX_W'(1);
      r_cnt  <= r_cnt + CNT_W'(w_hit);
    end
  end

  assign hit       = w_hit;
  assign out_count = r_cnt;

`ifdef DET_STREAM_STATS_EN
  logic [15:0] r_total;

  // Lifetime hit counter; saturates and is cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_total <= 16'h0000;
    end else if (w_hit && (r_total != 16'hFFFF)) begin
      r_total <= r_total + 16'h0001;
    end
  end

  assign total_count = r_total;
`endif

endmodule

// File: tb/tb_det_stream_ctrl.sv
// tb_det_stream_ctrl: directed bench with a result scoreboard for det_stream_ctrl.
// With DET_STREAM_STATS_EN defined, total_count is also checked, including saturation
// on a second instance configured for dense hits.
module tb_det_stream_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       hit;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_count;
`ifdef DET_STREAM_STATS_EN
  logic [15:0] total_count;
`endif

  always #5 clk = ~clk;

  det_stream_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .hit       (hit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count)
`ifdef DET_STREAM_STATS_EN
    ,
    .total_count (total_count)
`endif
  );

`ifdef DET_STREAM_STATS_EN
  // Dense-hit instance: pattern 11 over all-ones 32-bit words gives 32 hits per word.
  logic        s_in_valid;
  logic        s_in_ready;
  logic [31:0] s_in_data;
  logic        s_hit;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [5:0]  s_out_count;
  logic [15:0] s_total;
  int          s_words = 0;

  det_stream_ctrl #(.WORD_W(32), .PAT_W(2), .PATTERN(2'b11)) dut_stats (
    .clk         (clk),
    .reset       (reset),
    .flush       (1'b0),
    .in_valid    (s_in_valid),
    .in_ready    (s_in_ready),
    .in_data     (s_in_data),
    .hit         (s_hit),
    .out_valid   (s_out_valid),
    .out_ready   (s_out_ready),
    .out_count   (s_out_count),
    .total_count (s_total)
  );

  always @(posedge clk) begin
    if (s_out_valid && s_out_ready) s_words <= s_words + 1;
  end
`endif

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every consumed result is compared against the oldest expected count.
  always @(negedge clk) begin
    int e;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_result: got count %0d, expected no result", out_count);
      end else begin
        e = exp_q.pop_front();
        check("out_count", int'(out_count), e);
      end
    end
  end

  task automatic wait_ready(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check({name, "_ready_timeout"}, 0, 1);
  endtask

  // Offer one word, record the hit pattern (index i = i-th processed bit, MSB first).
  task automatic send_word(input logic [7:0] d, input int exp_cnt, input logic [7:0] exp_hits,
                           input logic do_flush, input string name);
    logic [7:0] hv;
    wait_ready(name);
    in_valid = 1'b1;
    in_data  = d;
    flush    = do_flush;
    exp_q.push_back(exp_cnt);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      hv[i] = hit;
    end
    check({name, "_hits"}, int'(hv), int'(exp_hits));
  endtask

  task automatic do_flush();
    wait_ready("flush");
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
`ifdef DET_STREAM_STATS_EN
    s_in_valid  = 1'b0;
    s_in_data   = 32'hFFFF_FFFF;
    s_out_ready = 1'b1;
`endif
    #12;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_count", int'(out_count), 0);
    check("rst_hit", int'(hit), 0);
`ifdef DET_STREAM_STATS_EN
    check("rst_total", int'(total_count), 0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // Single match on the last bit of 0x33.
    send_word(8'h33, 1, 8'h80, 1'b0, "w33");

    // Overlap and cross-boundary matches.
    do_flush();
    send_word(8'hCC, 1, 8'h20, 1'b0, "wCC_a");
    send_word(8'hCC, 2, 8'h22, 1'b0, "wCC_b");

    // Match spanning 0x03 -> 0x30, then the same words split by flushes.
    do_flush();
    send_word(8'h03, 0, 8'h00, 1'b0, "w03_a");
    send_word(8'h30, 1, 8'h08, 1'b0, "w30_a");
    do_flush();
    send_word(8'h03, 0, 8'h00, 1'b0, "w03_b");
    send_word(8'h30, 0, 8'h00, 1'b1, "w30_flush_same_cycle");

    // Backpressure on the result.
    do_flush();
    out_ready = 1'b0;
    send_word(8'h33, 1, 8'h80, 1'b0, "w33_bp");
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    in_valid = 1'b1;
    in_data  = 8'hCC;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_count", int'(out_count), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_hit", int'(hit), 0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    send_word(8'hCC, 1, 8'h20, 1'b0, "wCC_after_bp");
    drain();

    // Reset during bit 4 of 0xCC abandons the word.
    wait_ready("rst_mid");
    in_valid = 1'b1;
    in_data  = 8'hCC;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_out_count", int'(out_count), 0);
    check("mid_rst_hit", int'(hit), 0);
    @(negedge clk);
    reset = 1'b0;
    send_word(8'h33, 1, 8'h80, 1'b0, "w33_after_rst");
    drain();
`ifdef DET_STREAM_STATS_EN
    check("total_after_rst", int'(total_count), 1);

    // Saturation: 31 hits in the first word, then 32 per word.
    s_in_valid = 1'b1;
    t = 0;
    while (s_words < 2047 && t < 90000) begin
      @(negedge clk);
      t++;
    end
    check("total_2047_words", int'(s_total), 32'hFFDF);
    t = 0;
    while (s_words < 2049 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("total_saturated", int'(s_total), 32'hFFFF);
    s_in_valid = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
